// File: rtl/cic_interp.sv
// cic_interp: two-stage CIC interpolator (comb -> zero-stuff -> integrate) with a 16-bit saturating output.
//   i_clk          rising-edge clock
//   i_reset_n      asynchronous active-low reset
//   i_clk_enable   output-rate enable; all state holds while low
//   i_irate_in     interpolation rate minus one (R = i_irate_in + 1)
//   i_output_shift arithmetic right shift applied before saturation
//   i_data_in      signed input sample
//   i_in_valid     i_data_in valid, sampled only when o_data_req is high
//   o_data_req     combinational capture strobe for the next input sample
//   o_data_out     registered signed interpolated output
//   o_out_valid    high the cycle after each enabled cycle
//   o_underrun     1-cycle pulse after a capture with no valid sample
//   o_sat          high while o_data_out is clipped
module cic_interp #(
    parameter int INTERNAL_WIDTH = 48
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clk_enable,
    input  logic [15:0]        i_irate_in,
    input  logic [5:0]         i_output_shift,
    input  logic signed [15:0] i_data_in,
    input  logic               i_in_valid,
    output logic               o_data_req,
    output logic signed [15:0] o_data_out,
    output logic               o_out_valid,
    output logic               o_underrun,
    output logic               o_sat
);
    localparam int W = INTERNAL_WIDTH;
    localparam logic signed [W-1:0] MAX_OUT = W'(32767);
    localparam logic signed [W-1:0] MIN_OUT = -W'(32768);

    logic [15:0]         r_cnt;
    logic signed [W-1:0] r_d1, r_d2, r_u, r_i1, r_i2;
    logic signed [W-1:0] w_s, w_c1, w_c2, w_sh;
    logic                w_hi, w_lo;

    assign o_data_req = i_clk_enable && (r_cnt == 16'd0);
    // A missing sample is replaced by zero so the comb history stays consistent.
    assign w_s  = i_in_valid ? {{(W-16){i_data_in[15]}}, i_data_in} : '0;
    assign w_c1 = w_s - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_sh = r_i2 >>> i_output_shift;
    assign w_hi = w_sh > MAX_OUT;
    assign w_lo = w_sh < MIN_OUT;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_u         <= '0;
            r_i1        <= '0;
            r_i2        <= '0;
            o_data_out  <= '0;
            o_out_valid <= 1'b0;
            o_underrun  <= 1'b0;
            o_sat       <= 1'b0;
        end else begin
            o_out_valid <= i_clk_enable;
            // Updated every cycle so the flag never stretches across disabled cycles.
            o_underrun  <= o_data_req && !i_in_valid;
            if (i_clk_enable) begin
                // ">=" lets a lowered rate take effect at the next wrap without stalling.
                r_cnt <= (r_cnt >= i_irate_in) ? 16'd0 : r_cnt + 16'd1;
                if (o_data_req) begin
                    r_d1 <= w_s;
                    r_d2 <= w_c1;
                end
                r_u        <= o_data_req ? w_c2 : '0;
                r_i1       <= r_i1 + r_u;
                r_i2       <= r_i2 + r_i1;
                o_data_out <= w_hi ? 16'sh7fff : w_lo ? 16'sh8000 : w_sh[15:0];
                o_sat      <= w_hi || w_lo;
            end
        end
    end
endmodule
